// File: rtl/int_sequencer_if.sv
// Bus bundle between the interrupt/reset sequencer and memory.
// master: busy, addr, dout, mem_rw out, din in; slave: the reverse.
interface int_sequencer_if;
    logic        busy;
    logic [15:0] addr;
    logic [7:0]  dout;
    logic        mem_rw;
    logic [7:0]  din;

    modport master (
        output busy,
        output addr,
        output dout,
        output mem_rw,
        input  din
    );

    modport slave (
        input  busy,
        input  addr,
        input  dout,
        input  mem_rw,
        output din
    );
endinterface

// File: rtl/int_sequencer.sv
// 6502 reset/NMI/IRQ/BRK sequencer: pushes PCH, PCL, P, sets I, loads vector.
// Ports: clk, rst_n, nmi_n, irq_n, i_flag, boundary, brk_req, pc_in, p_in,
//        s_in in; bus (master); s_out/S_ld, pc_out/PC_ld, p_set_i out.
module int_sequencer #(
    parameter logic [15:0] NMI_VEC = 16'hFFFA,
    parameter logic [15:0] RES_VEC = 16'hFFFC,
    parameter logic [15:0] IRQ_VEC = 16'hFFFE,
    parameter logic [7:0]  S_RESET = 8'hFD
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        nmi_n,
    input  logic        irq_n,
    input  logic        i_flag,
    input  logic        boundary,
    input  logic        brk_req,
    input  logic [15:0] pc_in,
    input  logic [7:0]  p_in,
    input  logic [7:0]  s_in,
    int_sequencer_if.master bus,
    output logic [7:0]  s_out,
    output logic        S_ld,
    output logic [15:0] pc_out,
    output logic        PC_ld,
    output logic        p_set_i
);

    typedef enum logic [2:0] {
        RESET_HOLD,
        IDLE,
        PUSH_PCH,
        PUSH_PCL,
        PUSH_P,
        VEC_LO,
        VEC_HI,
        LOAD
    } state_t;

    state_t      r_state;
    logic [7:0]  r_sp;
    logic [7:0]  r_lo;
    logic [15:0] r_vec;
    logic        r_is_brk;
    logic        r_is_res;
    logic        r_nmi_prev;
    logic        r_nmi_pend;

    logic        w_nmi_edge;
    logic        w_start;
    logic [15:0] w_vec;

    // Edge register resets to 0 so a line held low through reset never fires.
    assign w_nmi_edge = r_nmi_prev && !nmi_n;
    assign w_start    = r_nmi_pend || brk_req || (!irq_n && !i_flag);
    assign w_vec      = r_is_res   ? RES_VEC :
                        r_nmi_pend ? NMI_VEC : IRQ_VEC;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= RESET_HOLD;
            r_sp       <= 8'h00;
            r_lo       <= 8'h00;
            r_vec      <= 16'h0000;
            r_is_brk   <= 1'b0;
            r_is_res   <= 1'b0;
            r_nmi_prev <= 1'b0;
            r_nmi_pend <= 1'b0;
        end else begin
            r_nmi_prev <= nmi_n;
            // A new edge wins over the clear so it is never lost.
            if (w_nmi_edge)
                r_nmi_pend <= 1'b1;
            else if (r_state == VEC_LO && !r_is_res)
                r_nmi_pend <= 1'b0;

            unique case (r_state)
                RESET_HOLD: begin
                    r_state  <= VEC_LO;
                    r_sp     <= S_RESET;
                    r_is_res <= 1'b1;
                    r_is_brk <= 1'b0;
                end
                IDLE: begin
                    if (boundary && w_start) begin
                        r_state  <= PUSH_PCH;
                        r_is_brk <= brk_req;
                        r_sp     <= s_in;
                        r_is_res <= 1'b0;
                    end
                end
                PUSH_PCH: begin
                    r_sp    <= r_sp - 8'd1;
                    r_state <= PUSH_PCL;
                end
                PUSH_PCL: begin
                    r_sp    <= r_sp - 8'd1;
                    r_state <= PUSH_P;
                end
                PUSH_P: begin
                    r_sp    <= r_sp - 8'd1;
                    r_state <= VEC_LO;
                end
                VEC_LO: begin
                    r_vec   <= w_vec;
                    r_state <= VEC_HI;
                end
                VEC_HI: begin
                    r_lo    <= bus.din;
                    r_state <= LOAD;
                end
                LOAD: begin
                    r_is_res <= 1'b0;
                    r_state  <= IDLE;
                end
            endcase
        end
    end

    assign s_out = r_sp;

    // Strobes are gated by rst_n so an aborted sequence never commits.
    always_comb begin
        bus.busy   = 1'b1;
        bus.addr   = 16'h0000;
        bus.dout   = 8'h00;
        bus.mem_rw = 1'b1;
        pc_out     = 16'h0000;
        PC_ld      = 1'b0;
        S_ld       = 1'b0;
        p_set_i    = 1'b0;
        unique case (r_state)
            RESET_HOLD: bus.addr = RES_VEC;
            IDLE:       bus.busy = 1'b0;
            PUSH_PCH: begin
                bus.addr   = {8'h01, r_sp};
                bus.mem_rw = 1'b0;
                bus.dout   = pc_in[15:8];
            end
            PUSH_PCL: begin
                bus.addr   = {8'h01, r_sp};
                bus.mem_rw = 1'b0;
                bus.dout   = pc_in[7:0];
            end
            PUSH_P: begin
                bus.addr   = {8'h01, r_sp};
                bus.mem_rw = 1'b0;
                // Bit 5 forced high, bit 4 carries the BRK flag.
                bus.dout   = (p_in & 8'hCF) | {2'b00, 1'b1, r_is_brk, 4'h0};
                p_set_i    = rst_n;
            end
            VEC_LO: begin
                bus.addr = w_vec;
                p_set_i  = rst_n && r_is_res;
            end
            VEC_HI: bus.addr = r_vec + 16'd1;
            LOAD: begin
                bus.addr = r_vec + 16'd1;
                pc_out   = {bus.din, r_lo};
                PC_ld    = rst_n;
                S_ld     = rst_n;
            end
        endcase
    end

endmodule

// File: tb/tb_int_sequencer.sv
// Directed bench for int_sequencer: vector table plus multi-cycle sequences.
// Memory model answers reads one cycle after the address.
module tb_int_sequencer;

    logic        clk = 1'b0;
    logic        rst_n, nmi_n, irq_n, i_flag, boundary, brk_req;
    logic [15:0] pc_in;
    logic [7:0]  p_in, s_in;
    logic [7:0]  s_out;
    logic        S_ld, PC_ld, p_set_i;
    logic [15:0] pc_out;

    int_sequencer_if bus ();

    int_sequencer dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .nmi_n    (nmi_n),
        .irq_n    (irq_n),
        .i_flag   (i_flag),
        .boundary (boundary),
        .brk_req  (brk_req),
        .pc_in    (pc_in),
        .p_in     (p_in),
        .s_in     (s_in),
        .bus      (bus),
        .s_out    (s_out),
        .S_ld     (S_ld),
        .pc_out   (pc_out),
        .PC_ld    (PC_ld),
        .p_set_i  (p_set_i)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [0:65535];
    logic [7:0] rdata = 8'h00;
    always @(posedge clk) rdata <= mem[bus.addr];
    assign bus.din = rdata;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [15:0] wa_q[$], ra_q[$], pc_q[$];
    logic [7:0]  wd_q[$], s_q[$];
    int          pcc_q[$];
    int          busy_cnt = 0;
    int          pset_cnt = 0;

    always @(negedge clk) begin
        if (bus.busy) busy_cnt = busy_cnt + 1;
        if (bus.busy && !bus.mem_rw) begin
            wa_q.push_back(bus.addr);
            wd_q.push_back(bus.dout);
        end
        if (bus.busy && bus.mem_rw) ra_q.push_back(bus.addr);
        if (PC_ld) begin
            pc_q.push_back(pc_out);
            pcc_q.push_back(cyc);
        end
        if (S_ld) s_q.push_back(s_out);
        if (p_set_i) pset_cnt = pset_cnt + 1;
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int w0, r0, p0, s0, b0, ps0;
    task automatic snap();
        w0  = wa_q.size();
        r0  = ra_q.size();
        p0  = pc_q.size();
        s0  = s_q.size();
        b0  = busy_cnt;
        ps0 = pset_cnt;
    endtask

    typedef struct {
        logic        irq_n, i_flag, brk, go;
        logic [7:0]  s, p;
        logic [15:0] pc;
        logic [15:0] wa[3];
        logic [7:0]  wd[3];
        logic [15:0] vec, pco;
        logic [7:0]  so;
    } vec_t;

    vec_t vt[6];
    int   t;

    initial begin
        for (int a = 0; a < 65536; a++) mem[a] = 8'h00;
        mem[16'hFFFA] = 8'hBC; mem[16'hFFFB] = 8'h9A;
        mem[16'hFFFC] = 8'h34; mem[16'hFFFD] = 8'h12;
        mem[16'hFFFE] = 8'h78; mem[16'hFFFF] = 8'h56;

        vt[0] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'hFF, 8'hC3, 16'hABCD,
                  '{16'h0, 16'h0, 16'h0}, '{8'h0, 8'h0, 8'h0},
                  16'h0, 16'h0, 8'h0};
        vt[1] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'hFF, 8'hC3, 16'hABCD,
                  '{16'h01FF, 16'h01FE, 16'h01FD}, '{8'hAB, 8'hCD, 8'hE3},
                  16'hFFFE, 16'h5678, 8'hFC};
        vt[2] = '{1'b1, 1'b0, 1'b1, 1'b1, 8'hF0, 8'h00, 16'h1002,
                  '{16'h01F0, 16'h01EF, 16'h01EE}, '{8'h10, 8'h02, 8'h30},
                  16'hFFFE, 16'h5678, 8'hED};
        vt[3] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h01, 8'hFF, 16'h5678,
                  '{16'h0101, 16'h0100, 16'h01FF}, '{8'h56, 8'h78, 8'hEF},
                  16'hFFFE, 16'h5678, 8'hFE};
        vt[4] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'hFF, 8'h00, 16'h0000,
                  '{16'h0, 16'h0, 16'h0}, '{8'h0, 8'h0, 8'h0},
                  16'h0, 16'h0, 8'h0};
        vt[5] = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h80, 8'h0F, 16'h0000,
                  '{16'h0180, 16'h017F, 16'h017E}, '{8'h00, 8'h00, 8'h3F},
                  16'hFFFE, 16'h5678, 8'h7D};

        rst_n = 1'b0; nmi_n = 1'b1; irq_n = 1'b1; i_flag = 1'b0;
        boundary = 1'b0; brk_req = 1'b0;
        pc_in = 16'h0; p_in = 8'h0; s_in = 8'h0;
        repeat (3) tick();

        chk("rst busy", bus.busy, 1);
        chk("rst addr", bus.addr, 16'hFFFC);
        chk("rst rw", bus.mem_rw, 1);
        chk("rst dout", bus.dout, 0);
        chk("rst s_out", s_out, 0);
        chk("rst pc_out", pc_out, 0);
        chk("rst strobes", {PC_ld, S_ld, p_set_i}, 0);

        // Reset release: vector at release+3, no pushes.
        snap();
        t = cyc;
        rst_n = 1'b1;
        repeat (8) tick();
        chk("res writes", wa_q.size() - w0, 0);
        chk("res pcld n", pc_q.size() - p0, 1);
        chk("res sld n", s_q.size() - s0, 1);
        chk("res pset n", pset_cnt - ps0, 1);
        chk("res busy cyc", busy_cnt - b0, 4);
        if (pc_q.size() > p0) begin
            chk("res pc", pc_q[p0], 16'h1234);
            chk("res pc cyc", pcc_q[p0], t + 3);
        end
        if (s_q.size() > s0) chk("res s", s_q[s0], 8'hFD);

        for (int i = 0; i < 6; i++) begin
            snap();
            t = cyc;
            irq_n = vt[i].irq_n; i_flag = vt[i].i_flag;
            brk_req = vt[i].brk;
            s_in = vt[i].s; p_in = vt[i].p; pc_in = vt[i].pc;
            boundary = 1'b1;
            tick();
            boundary = 1'b0; brk_req = 1'b0; irq_n = 1'b1;
            repeat (9) tick();
            chk($sformatf("v%0d busy", i), busy_cnt - b0,
                vt[i].go ? 6 : 0);
            chk($sformatf("v%0d nwr", i), wa_q.size() - w0,
                vt[i].go ? 3 : 0);
            chk($sformatf("v%0d npc", i), pc_q.size() - p0,
                vt[i].go ? 1 : 0);
            chk($sformatf("v%0d pset", i), pset_cnt - ps0,
                vt[i].go ? 1 : 0);
            if (vt[i].go) begin
                for (int j = 0; j < 3; j++) begin
                    if (w0 + j < wa_q.size()) begin
                        chk($sformatf("v%0d wa%0d", i, j), wa_q[w0+j],
                            vt[i].wa[j]);
                        chk($sformatf("v%0d wd%0d", i, j), wd_q[w0+j],
                            vt[i].wd[j]);
                    end
                end
                if (r0 + 1 < ra_q.size()) begin
                    chk($sformatf("v%0d vlo", i), ra_q[r0], vt[i].vec);
                    chk($sformatf("v%0d vhi", i), ra_q[r0+1],
                        vt[i].vec + 16'd1);
                end
                if (pc_q.size() > p0) begin
                    chk($sformatf("v%0d pc", i), pc_q[p0], vt[i].pco);
                    chk($sformatf("v%0d pc cyc", i), pcc_q[p0], t + 6);
                end
                if (s_q.size() > s0)
                    chk($sformatf("v%0d s", i), s_q[s0], vt[i].so);
            end
        end

        // NMI held low 20 cycles, boundary every 5: exactly one sequence.
        i_flag = 1'b0; irq_n = 1'b1;
        s_in = 8'hFF; pc_in = 16'h1111; p_in = 8'h00;
        snap();
        nmi_n = 1'b0;
        for (int k = 0; k < 20; k++) begin
            boundary = (k % 5 == 1);
            tick();
        end
        boundary = 1'b0; nmi_n = 1'b1;
        repeat (3) tick();
        chk("nmi npc", pc_q.size() - p0, 1);
        chk("nmi nwr", wa_q.size() - w0, 3);
        if (pc_q.size() > p0) chk("nmi pc", pc_q[p0], 16'h9ABC);
        if (wd_q.size() > w0 + 2) chk("nmi p", wd_q[w0+2], 8'h20);
        if (ra_q.size() > r0) chk("nmi vec", ra_q[r0], 16'hFFFA);

        // NMI edge during PUSH_PCL hijacks an IRQ.
        snap();
        irq_n = 1'b0; s_in = 8'hFF; pc_in = 16'h2222; p_in = 8'h00;
        boundary = 1'b1;
        tick();
        boundary = 1'b0; irq_n = 1'b1;
        tick();
        nmi_n = 1'b0;
        repeat (6) tick();
        nmi_n = 1'b1;
        tick();
        chk("hij npc", pc_q.size() - p0, 1);
        if (pc_q.size() > p0) chk("hij pc", pc_q[p0], 16'h9ABC);
        if (wd_q.size() > w0 + 2) chk("hij p", wd_q[w0+2], 8'h20);
        if (ra_q.size() > r0) chk("hij vec", ra_q[r0], 16'hFFFA);
        boundary = 1'b1;
        tick();
        boundary = 1'b0;
        repeat (8) tick();
        chk("hij clear", pc_q.size() - p0, 1);

        // NMI edge after VEC_LO stays pending for the next boundary.
        snap();
        irq_n = 1'b0; boundary = 1'b1;
        tick();
        boundary = 1'b0; irq_n = 1'b1;
        repeat (4) tick();
        nmi_n = 1'b0;
        tick();
        nmi_n = 1'b1;
        repeat (3) tick();
        boundary = 1'b1;
        tick();
        boundary = 1'b0;
        repeat (8) tick();
        chk("late npc", pc_q.size() - p0, 2);
        if (pc_q.size() > p0 + 1) begin
            chk("late pc0", pc_q[p0], 16'h5678);
            chk("late pc1", pc_q[p0+1], 16'h9ABC);
        end

        // Reset in PUSH_P aborts the sequence, then reset runs.
        snap();
        irq_n = 1'b0; boundary = 1'b1;
        tick();
        boundary = 1'b0; irq_n = 1'b1;
        repeat (2) tick();
        rst_n = 1'b0;
        repeat (2) tick();
        t = cyc;
        rst_n = 1'b1;
        repeat (6) tick();
        chk("abort npc", pc_q.size() - p0, 1);
        chk("abort ns", s_q.size() - s0, 1);
        chk("abort pset", pset_cnt - ps0, 1);
        if (pc_q.size() > p0) begin
            chk("abort pc", pc_q[p0], 16'h1234);
            chk("abort pc cyc", pcc_q[p0], t + 3);
        end
        if (s_q.size() > s0) chk("abort s", s_q[s0], 8'hFD);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
